rbr_serializer_3ch: RTL and testbench

Upstream feeder for the online sum-of-three-squares stage. Accepts three parallel two's-complement fractional operands over a valid/ready handshake. Converts each operand exactly to a redundant-binary signed_digit stream (rbr_pkg) and emits the three streams MSB-first, one digit per clock, with an enable strobe. Appends FLUSH_DIGITS zero digits so the downstream online module can drain its online delay.

---
 rtl/rbr_serializer_3ch.sv | 155 +++++++++++++++
 tb/tb_rbr_serializer_3ch.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rbr_serializer_3ch.sv
// rbr_serializer_3ch: captures three two's-complement fractions and streams them MSB-first as
// redundant-binary signed digits, one per clock, followed by FLUSH_DIGITS zero digits.
// Optional feature macro: RBR_SERIALIZER_B2B_EN (zero-bubble back-to-back frames).

package rbr_pkg;
   typedef struct packed {
      logic plus;
      logic minus;
   } signed_digit;
endpackage

module rbr_serializer_3ch #(
   parameter int unsigned WIDTH        = 15,
   parameter int unsigned FLUSH_DIGITS = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     x_in,
   input  logic [WIDTH-1:0]     y_in,
   input  logic [WIDTH-1:0]     z_in,
   output rbr_pkg::signed_digit x,
   output rbr_pkg::signed_digit y,
   output rbr_pkg::signed_digit z,
   output logic                 en,
   output logic                 first,
   output logic                 last
);

   localparam int unsigned CntW = $clog2(WIDTH + FLUSH_DIGITS + 1);
   localparam logic [CntW-1:0] LastSig = CntW'(WIDTH - 1);
   // Only meaningful when FLUSH_DIGITS != 0; the flush state is unreachable otherwise.
   localparam logic [CntW-1:0] LastFlush = (FLUSH_DIGITS != 0) ? CntW'(FLUSH_DIGITS - 1) : '0;

   typedef enum logic [1:0] {StIdle, StShift, StFlush} state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]     xs_q, xs_d, ys_q, ys_d, zs_q, zs_d;
   rbr_pkg::signed_digit x_q, x_d, y_q, y_d, z_q, z_d;
   logic                 en_q, en_d, first_q, first_d, last_q, last_d, ready_q, ready_d;
   logic                 accept;

   assign accept = in_valid && ready_q;

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      xs_d    = xs_q;
      ys_d    = ys_q;
      zs_d    = zs_q;
      x_d     = '0;
      y_d     = '0;
      z_d     = '0;
      en_d    = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;

      if (accept) begin
         // Digit 0 carries the sign bit as a negative digit; remaining bits wait in the shifters.
         state_d = StShift;
         cnt_d   = '0;
         xs_d    = {x_in[WIDTH-2:0], 1'b0};
         ys_d    = {y_in[WIDTH-2:0], 1'b0};
         zs_d    = {z_in[WIDTH-2:0], 1'b0};
         x_d     = '{plus: 1'b0, minus: x_in[WIDTH-1]};
         y_d     = '{plus: 1'b0, minus: y_in[WIDTH-1]};
         z_d     = '{plus: 1'b0, minus: z_in[WIDTH-1]};
         en_d    = 1'b1;
         first_d = 1'b1;
      end else begin
         unique case (state_q)
            StShift: begin
               if (cnt_q != LastSig) begin
                  cnt_d  = cnt_q + CntW'(1);
                  x_d    = '{plus: xs_q[WIDTH-1], minus: 1'b0};
                  y_d    = '{plus: ys_q[WIDTH-1], minus: 1'b0};
                  z_d    = '{plus: zs_q[WIDTH-1], minus: 1'b0};
                  xs_d   = {xs_q[WIDTH-2:0], 1'b0};
                  ys_d   = {ys_q[WIDTH-2:0], 1'b0};
                  zs_d   = {zs_q[WIDTH-2:0], 1'b0};
                  en_d   = 1'b1;
                  last_d = (FLUSH_DIGITS == 0) && (cnt_d == LastSig);
               end else if (FLUSH_DIGITS != 0) begin
                  state_d = StFlush;
                  cnt_d   = '0;
                  en_d    = 1'b1;
                  last_d  = (FLUSH_DIGITS == 1);
               end else begin
                  state_d = StIdle;
               end
            end
            StFlush: begin
               if (cnt_q != LastFlush) begin
                  cnt_d  = cnt_q + CntW'(1);
                  en_d   = 1'b1;
                  last_d = (cnt_d == LastFlush);
               end else begin
                  state_d = StIdle;
               end
            end
            default: ;
         endcase
      end

`ifdef RBR_SERIALIZER_B2B_EN
      // Accepting during the last digit lets the next frame follow without a gap.
      ready_d = (state_d == StIdle) || last_d;
`else
      ready_d = (state_d == StIdle);
`endif
   end

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         xs_q    <= '0;
         ys_q    <= '0;
         zs_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         en_q    <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         xs_q    <= xs_d;
         ys_q    <= ys_d;
         zs_q    <= zs_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         en_q    <= en_d;
         first_q <= first_d;
         last_q  <= last_d;
         ready_q <= ready_d;
      end
   end

   assign x        = x_q;
   assign y        = y_q;
   assign z        = z_q;
   assign en       = en_q;
   assign first    = first_q;
   assign last     = last_q;
   assign in_ready = ready_q;

endmodule

// File: tb/tb_rbr_serializer_3ch.sv
// Testbench for rbr_serializer_3ch: table-driven frames plus hand-written multi-cycle sequences.
module tb_rbr_serializer_3ch;

   localparam int W = 15;
   localparam int F = 3;
   localparam int L = W + F;
`ifdef RBR_SERIALIZER_B2B_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] xo;
      logic [W-1:0] yo;
      logic [W-1:0] zo;
      int           ex;   // expected value scaled by 2^14
      int           ey;
      int           ez;
      logic [1:0]   dx;   // expected digit 0 {plus,minus}
      logic [1:0]   dy;
      logic [1:0]   dz;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic v0 = 1'b0;
   logic [W-1:0] x_in = '0, y_in = '0, z_in = '0;
   logic in_ready, en, first, last;
   logic ready0, en0, first0, last0;
   rbr_pkg::signed_digit x, y, z, x0, y0, z0;

   int checks = 0;
   int failures = 0;
   vec_t vecs[5];

   always #5 clk = ~clk;

   rbr_serializer_3ch #(.WIDTH(W), .FLUSH_DIGITS(F)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x_in(x_in), .y_in(y_in), .z_in(z_in), .x(x), .y(y), .z(z),
      .en(en), .first(first), .last(last)
   );

   rbr_serializer_3ch #(.WIDTH(W), .FLUSH_DIGITS(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(ready0),
      .x_in(x_in), .y_in(y_in), .z_in(z_in), .x(x0), .y(y0), .z(z0),
      .en(en0), .first(first0), .last(last0)
   );

   task automatic chk(input string nm, input logic signed [31:0] act,
                      input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic idle_chk(input string nm);
      chk({nm, " idle en"}, en, 0);
      chk({nm, " idle ready"}, in_ready, 1);
      chk({nm, " idle digits"}, {x.plus, x.minus, y.plus, y.minus, z.plus, z.minus}, 0);
      chk({nm, " idle first/last"}, {first, last}, 0);
   endtask

   // Caller is at the negedge of frame cycle 1. Optionally scrambles operands mid-frame and
   // presents nv on the final cycle.
   task automatic collect(input string nm, input vec_t v, input bit junk, input vec_t nv);
      int ax, ay, az, bad11, flushnz;
      ax = 0; ay = 0; az = 0; bad11 = 0; flushnz = 0;
      for (int cyc = 1; cyc <= L; cyc++) begin
         if (cyc > 1) @(negedge clk);
         chk($sformatf("%s en c%0d", nm, cyc), en, 1);
         chk($sformatf("%s first c%0d", nm, cyc), first, (cyc == 1));
         chk($sformatf("%s last c%0d", nm, cyc), last, (cyc == L));
         chk($sformatf("%s ready c%0d", nm, cyc), in_ready, (B2B && cyc == L));
         if (cyc == 1) begin
            chk({nm, " x digit0"}, {x.plus, x.minus}, v.dx);
            chk({nm, " y digit0"}, {y.plus, y.minus}, v.dy);
            chk({nm, " z digit0"}, {z.plus, z.minus}, v.dz);
         end
         if (cyc <= W) begin
            ax = ax * 2 + int'(x.plus) - int'(x.minus);
            ay = ay * 2 + int'(y.plus) - int'(y.minus);
            az = az * 2 + int'(z.plus) - int'(z.minus);
         end else begin
            flushnz += int'({x.plus, x.minus} != 2'b00) + int'({y.plus, y.minus} != 2'b00)
                     + int'({z.plus, z.minus} != 2'b00);
         end
         bad11 += int'(x.plus & x.minus) + int'(y.plus & y.minus) + int'(z.plus & z.minus);
         if (junk) begin
            if (cyc < L) begin
               x_in = W'($urandom); y_in = W'($urandom); z_in = W'($urandom);
            end else begin
               x_in = nv.xo; y_in = nv.yo; z_in = nv.zo;
            end
         end
      end
      chk({nm, " x value"}, ax, v.ex);
      chk({nm, " y value"}, ay, v.ey);
      chk({nm, " z value"}, az, v.ez);
      chk({nm, " flush zero"}, flushnz, 0);
      chk({nm, " no 11 digit"}, bad11, 0);
   endtask

   task automatic run_vec(input string nm, input vec_t v);
      x_in = v.xo; y_in = v.yo; z_in = v.zo;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      collect(nm, v, 1'b0, v);
      @(negedge clk);
      idle_chk(nm);
   endtask

   initial begin
      int a0;
      vecs[0] = '{15'h3000, 15'h3000, 15'h3000, 12288, 12288, 12288, 2'b00, 2'b00, 2'b00};
      vecs[1] = '{15'h6000, 15'h4000, 15'h3FFF, -8192, -16384, 16383, 2'b01, 2'b01, 2'b00};
      vecs[2] = '{15'h7FFF, 15'h0001, 15'h0000, -1, 1, 0, 2'b01, 2'b00, 2'b00};
      vecs[3] = '{15'h2AAA, 15'h5555, 15'h1234, 10922, -10923, 4660, 2'b00, 2'b01, 2'b00};
      vecs[4] = '{15'h0F0F, 15'h7000, 15'h2001, 3855, -4096, 8193, 2'b00, 2'b01, 2'b00};

      // Reset held with valid high: ready, no digits.
      x_in = vecs[0].xo; y_in = vecs[0].yo; z_in = vecs[0].zo;
      in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      idle_chk("reset");
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      collect("vec0", vecs[0], 1'b0, vecs[0]);
      @(negedge clk);
      idle_chk("vec0");

      for (int i = 1; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Valid held high, operands scrambled mid-frame.
      x_in = vecs[1].xo; y_in = vecs[1].yo; z_in = vecs[1].zo;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      collect("hold1", vecs[1], 1'b1, vecs[4]);
      if (!B2B) begin
         @(negedge clk);
         chk("hold gap en", en, 0);
         chk("hold gap ready", in_ready, 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      collect("hold2", vecs[4], 1'b0, vecs[4]);
      @(negedge clk);
      idle_chk("hold2");

      // Reset asserted while digit 7 is on the outputs.
      x_in = vecs[0].xo; y_in = vecs[0].yo; z_in = vecs[0].zo;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         if (cyc > 1) @(negedge clk);
         chk($sformatf("abort en c%0d", cyc), en, 1);
      end
      rst_n = 1'b0;
      #1;
      chk("abort en", en, 0);
      chk("abort ready", in_ready, 1);
      chk("abort last", last, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec("after_abort", vecs[2]);

      // FLUSH_DIGITS=0 instance: 15 digits, last on digit 14.
      x_in = vecs[0].xo; y_in = vecs[0].yo; z_in = vecs[0].zo;
      v0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v0 = 1'b0;
      a0 = 0;
      for (int cyc = 1; cyc <= W; cyc++) begin
         if (cyc > 1) @(negedge clk);
         chk($sformatf("nf en c%0d", cyc), en0, 1);
         chk($sformatf("nf first c%0d", cyc), first0, (cyc == 1));
         chk($sformatf("nf last c%0d", cyc), last0, (cyc == W));
         a0 = a0 * 2 + int'(x0.plus) - int'(x0.minus);
      end
      chk("nf x value", a0, 12288);
      @(negedge clk);
      chk("nf idle en", en0, 0);
      chk("nf idle ready", ready0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
